// File: rtl/mm_pkg.sv
// Shared definitions for the mm_wrapper host controller.
//   state_t : controller FSM states
//   res_w   : result element width, 2*DW + clog2(N)
//   addr_w  : bank address width, clog2(N), never narrower than 1 bit
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_RD_ROW,
    S_EMIT,
    S_FIN
  } state_t;

  function automatic int res_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_host_ctrl.sv
// Host-side controller for mm_wrapper.
// Loads matrix A then matrix B from a row-major element stream into the
// wrapper's per-bank ROM write ports, pulses start, waits COMP_CYC cycles,
// then reads the result banks row by row and streams the NxN product out
// in row-major order.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input element handshake, in_data = A then B
//   out_valid/out_ready   result element handshake, out_data (RW bits)
//   busy                  high whenever the FSM is not idle
//   done                  one-cycle pulse after the last result beat
//   mat_a_*/mat_b_*       per-bank ROM write ports (data, addr, we)
//   mm_start              one-cycle start pulse to mm_wrapper
//   res_rd_addr/res_data  per-bank result read port (1-cycle latency)
//   cycle_cnt             busy-cycle counter, only with MM_HOST_PERF_EN
//
// Build option: define MM_HOST_PERF_EN to add the cycle_cnt port.
module mm_host_ctrl
  import mm_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = 2,
  parameter int COMP_CYC = 64,
  localparam int AW      = addr_w(N),
  localparam int RW      = res_w(N, DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] mat_a_data  [0:N-1],
  output logic [AW-1:0] mat_a_addr  [0:N-1],
  output logic [0:N-1]  mat_a_we,
  output logic [DW-1:0] mat_b_data  [0:N-1],
  output logic [AW-1:0] mat_b_addr  [0:N-1],
  output logic [0:N-1]  mat_b_we,
  output logic          mm_start,
  output logic [AW-1:0] res_rd_addr [0:N-1],
  input  logic [RW-1:0] res_data    [0:N-1]
`ifdef MM_HOST_PERF_EN
  ,
  output logic [31:0]   cycle_cnt
`endif
);

  localparam int WCW = $clog2(COMP_CYC + 1);
  localparam logic [2*AW-1:0] K_LAST = '1;   // N*N-1, N is a power of two
  localparam logic [AW-1:0]   IX_LAST = '1;  // N-1
  localparam logic [WCW-1:0]  W_LAST = WCW'(COMP_CYC - 1);

  state_t          state_q, state_d;
  logic [2*AW-1:0] k_q, k_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic            fresh_q, fresh_d;
  logic            busy_q, done_q, start_q, out_valid_q, in_ready_q;
  logic [RW-1:0]   rowbuf_q [0:N-1];

  logic [AW-1:0]   kr, kc;
  logic            ld_a, ld_b, rd_phase;

  assign kr = k_q[2*AW-1:AW];
  assign kc = k_q[AW-1:0];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    row_d   = row_q;
    col_d   = col_q;
    fresh_d = fresh_q;
    case (state_q)
      S_IDLE: begin
        // Entry cycle only; the element is taken on the next cycle.
        if (in_valid) begin
          state_d = S_LOAD_A;
          k_d     = '0;
        end
      end
      S_LOAD_A: begin
        if (in_valid) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wait_d  = '0;
        row_d   = '0;
      end
      S_WAIT: begin
        if (wait_q == W_LAST) state_d = S_RD_ROW;
        else                  wait_d  = wait_q + 1'b1;
      end
      S_RD_ROW: begin
        state_d = S_EMIT;
        col_d   = '0;
        fresh_d = 1'b1;
      end
      S_EMIT: begin
        fresh_d = 1'b0;
        if (out_ready) begin
          col_d = col_q + 1'b1;
          if (col_q == IX_LAST) begin
            if (row_q == IX_LAST) begin
              state_d = S_FIN;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_RD_ROW;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      wait_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      fresh_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      row_q       <= row_d;
      col_q       <= col_d;
      fresh_q     <= fresh_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      start_q     <= (state_d == S_START);
      out_valid_q <= (state_d == S_EMIT);
      in_ready_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    end
  end

  // Row buffer: captured on the first EMIT cycle, when the bank read issued
  // in RD_ROW has landed on res_data.
  always_ff @(posedge clk) begin
    if (state_q == S_EMIT && fresh_q) rowbuf_q <= res_data;
  end

  assign ld_a     = (state_q == S_LOAD_A);
  assign ld_b     = (state_q == S_LOAD_B);
  assign rd_phase = (state_q == S_RD_ROW) || (state_q == S_EMIT);

  // Bank write demux: A(r,c) -> bank r addr c, B(r,c) -> bank c addr r.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mat_a_we[i]    = in_valid && ld_a && (kr == AW'(i));
      mat_a_addr[i]  = ld_a ? kc : '0;
      mat_a_data[i]  = ld_a ? in_data : '0;
      mat_b_we[i]    = in_valid && ld_b && (kc == AW'(i));
      mat_b_addr[i]  = ld_b ? kr : '0;
      mat_b_data[i]  = ld_b ? in_data : '0;
      // Address held through EMIT so res_data stays on the current row.
      res_rd_addr[i] = rd_phase ? row_q : '0;
    end
  end

  // First EMIT beat comes straight from the bank outputs; later beats from
  // the captured copy. Both carry the same row, so out_data is stable.
  assign out_data  = out_valid_q ? (fresh_q ? res_data[col_q] : rowbuf_q[col_q]) : '0;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mm_start  = start_q;

`ifdef MM_HOST_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  // Clears when a load begins, counts every busy cycle, holds while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_IDLE) cnt_d = cnt_q + 32'd1;
    else if (in_valid)     cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mm_host_ctrl.sv
// Bench for mm_host_ctrl with a behavioural mm_wrapper partner (ROM banks,
// delayed matrix product, 1-cycle synchronous result read).
// Build option: MM_HOST_PERF_EN adds cycle_cnt checks.
module tb_mm_host_ctrl;

  localparam int N        = 4;
  localparam int DW       = 2;
  localparam int COMP_CYC = 64;
  localparam int AW       = 2;
  localparam int RW       = 6;
  localparam int NN       = N * N;
  localparam int EXP_BUSY = 2 * NN + 1 + COMP_CYC + N * (N + 1) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] mat_a_data  [0:N-1];
  logic [AW-1:0] mat_a_addr  [0:N-1];
  logic [0:N-1]  mat_a_we;
  logic [DW-1:0] mat_b_data  [0:N-1];
  logic [AW-1:0] mat_b_addr  [0:N-1];
  logic [0:N-1]  mat_b_we;
  logic          mm_start;
  logic [AW-1:0] res_rd_addr [0:N-1];
  logic [RW-1:0] res_data    [0:N-1];
`ifdef MM_HOST_PERF_EN
  logic [31:0]   cycle_cnt;
`endif

  mm_host_ctrl #(.N(N), .DW(DW), .COMP_CYC(COMP_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .mat_a_data(mat_a_data), .mat_a_addr(mat_a_addr), .mat_a_we(mat_a_we),
    .mat_b_data(mat_b_data), .mat_b_addr(mat_b_addr), .mat_b_we(mat_b_we),
    .mm_start(mm_start), .res_rd_addr(res_rd_addr), .res_data(res_data)
`ifdef MM_HOST_PERF_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mm_wrapper partner
  logic [DW-1:0] rom_a   [0:N-1][0:N-1];
  logic [DW-1:0] rom_b   [0:N-1][0:N-1];
  logic [RW-1:0] res_mem [0:N-1][0:N-1];
  int            wcnt = 0;

  function automatic logic [RW-1:0] dot(input int r, input int c);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(rom_a[r][k]) * int'(rom_b[c][k]);
    return RW'(s);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mat_a_we[i]) rom_a[i][mat_a_addr[i]] <= mat_a_data[i];
      if (mat_b_we[i]) rom_b[i][mat_b_addr[i]] <= mat_b_data[i];
      res_data[i] <= res_mem[i][res_rd_addr[i]];
    end
    if (mm_start) begin
      wcnt <= COMP_CYC;
      for (int b = 0; b < N; b++)
        for (int a = 0; a < N; a++) res_mem[b][a] <= '1;
    end else if (wcnt > 0) begin
      wcnt <= wcnt - 1;
      if (wcnt == 1)
        for (int c = 0; c < N; c++)
          for (int r = 0; r < N; r++) res_mem[c][r] <= dot(r, c);
    end
  end

  // Scoreboard state
  int            vectors = 0;
  int            miscompares = 0;
  int            run_id = 0;
  int            out_mode = 0;
  int            drv_idx = 0;
  logic [DW-1:0] stim    [0:2*NN-1];
  logic [RW-1:0] exp_out [0:NN-1];
  int            ob_cnt, done_cnt, start_cnt, busy_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready generator
  initial begin
    int pat;
    pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        1:       out_ready = ((pat % 4) == 3);
        2:       out_ready = 1'(($urandom_range(1)));
        default: out_ready = 1'b1;
      endcase
      pat++;
    end
  end

  // Per-cycle compare process
  initial begin
    int            seen_run, idx, r, c;
    logic          prev_stall;
    logic [RW-1:0] prev_data;
    logic [0:N-1]  ew;
    seen_run = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    ob_cnt = 0; done_cnt = 0; start_cnt = 0; busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (run_id != seen_run) begin
        seen_run = run_id;
        ob_cnt = 0; done_cnt = 0; start_cnt = 0; busy_cyc = 0;
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        idx = drv_idx;
        r = (idx % NN) / N;
        c = idx % N;
        ew = '0;
        if (idx < NN) begin
          ew[r] = 1'b1;
          check("we_a", 32'(mat_a_we), 32'(ew));
          check("we_b_quiet", 32'(mat_b_we), 0);
          check("addr_a", 32'(mat_a_addr[r]), c);
          check("data_a", 32'(mat_a_data[r]), 32'(in_data));
        end else begin
          ew[c] = 1'b1;
          check("we_b", 32'(mat_b_we), 32'(ew));
          check("we_a_quiet", 32'(mat_a_we), 0);
          check("addr_b", 32'(mat_b_addr[c]), r);
          check("data_b", 32'(mat_b_data[c]), 32'(in_data));
        end
      end else begin
        check("we_idle", 32'({mat_a_we, mat_b_we}), 0);
      end
      if (mm_start) start_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (ob_cnt < NN) check("out_beat", 32'(out_data), 32'(exp_out[ob_cnt]));
        else             check("extra_beat", ob_cnt, NN - 1);
        ob_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic load(input int beats, input int gap);
    int   budget;
    logic hs;
    drv_idx = 0;
    budget = 0;
    while (drv_idx < beats && budget < 4000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = stim[drv_idx];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) drv_idx++;
      budget++;
    end
    in_valid = 1'b0;
    check("load_beats", drv_idx, beats);
  endtask

  task automatic set_golden();
    int s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += int'(stim[r*N+k]) * int'(stim[NN+k*N+c]);
        exp_out[r*N+c] = RW'(s);
      end
  endtask

  task automatic run_case(input int gap, input int mode, input int exp_busy);
    logic got;
    out_mode = mode;
    run_id++;
    load(2 * NN, gap);
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      got = done;
    end
    check("done_seen", 32'(got), 1);
    repeat (3) @(negedge clk);
    check("out_beats", ob_cnt, NN);
    check("done_pulses", done_cnt, 1);
    check("start_pulses", start_cnt, 1);
    check("busy_after", 32'(busy), 0);
    if (exp_busy > 0) check("busy_cycles", busy_cyc, exp_busy);
`ifdef MM_HOST_PERF_EN
    check("cycle_cnt_vs_busy", cycle_cnt, busy_cyc);
    if (exp_busy > 0) check("cycle_cnt", cycle_cnt, exp_busy);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [RW-1:0] b_lit [0:NN-1];
    b_lit = '{0, 1, 2, 3, 3, 2, 1, 0, 1, 1, 1, 1, 2, 0, 2, 0};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_start", 32'(mm_start), 0);
    check("rst_we", 32'({mat_a_we, mat_b_we}), 0);
    check("rst_out_data", 32'(out_data), 0);
`ifdef MM_HOST_PERF_EN
    check("rst_cycle_cnt", cycle_cnt, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A = I, B = literal, no stalls: output must be B.
    for (int i = 0; i < NN; i++) begin
      stim[i] = ((i / N) == (i % N)) ? DW'(1) : DW'(0);
      stim[NN+i] = DW'(b_lit[i]);
      exp_out[i] = b_lit[i];
    end
    run_case(0, 0, EXP_BUSY);

    // All 3s: every element is 4*9 = 36.
    for (int i = 0; i < 2 * NN; i++) stim[i] = DW'(3);
    for (int i = 0; i < NN; i++) exp_out[i] = RW'(36);
    run_case(0, 0, EXP_BUSY);

    // Random data with 50% input gaps.
    for (int i = 0; i < 2 * NN; i++) stim[i] = DW'($urandom_range(3));
    set_golden();
    run_case(50, 0, 0);

    // Random data, output throttled 3 low / 1 high.
    for (int i = 0; i < 2 * NN; i++) stim[i] = DW'($urandom_range(3));
    set_golden();
    run_case(0, 1, 0);

    // Abort after 7 B beats, then reload A = I, B = I.
    for (int i = 0; i < 2 * NN; i++) stim[i] = DW'($urandom_range(3));
    out_mode = 0;
    run_id++;
    load(NN + 7, 0);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_we", 32'({mat_a_we, mat_b_we}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NN; i++) begin
      stim[i] = ((i / N) == (i % N)) ? DW'(1) : DW'(0);
      stim[NN+i] = stim[i];
      exp_out[i] = ((i / N) == (i % N)) ? RW'(1) : RW'(0);
    end
    run_case(0, 2, 0);

    // A few more random runs with mixed gaps and back-pressure.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2 * NN; i++) stim[i] = DW'($urandom_range(3));
      set_golden();
      run_case(30, 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
